// File: rtl/mm_job_scheduler.sv
// Round-robin job scheduler sharing one systolic matmul array among NUM_REQ requesters.
// Optional WAIT watchdog is compiled in with `define MM_SCHED_TIMEOUT_EN.
module mm_job_scheduler #(
    parameter int ARRAY_SIZE     = 3,
    parameter int DATA_WIDTH     = 8,
    parameter int NUM_REQ        = 2,
    parameter int MAX_MATRICES   = 2,
    parameter int SLOT_W         = 2,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int NUM_ELEM      = ARRAY_SIZE * ARRAY_SIZE,
    localparam int IDX_W         = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1,
    localparam int ID_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*SLOT_W-1:0]      req_slot,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           arr_start,
    output logic [SLOT_W-1:0]              arr_slot,
    input  logic                           arr_busy,
    input  logic                           arr_done,
    input  logic [NUM_ELEM*DATA_WIDTH-1:0] arr_result,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic signed [DATA_WIDTH-1:0]   res_data,
    output logic [IDX_W-1:0]               res_index,
    output logic [ID_W-1:0]                res_id,
    output logic                           res_last,
    output logic                           sched_idle,
    output logic                           err_slot,
    output logic                           err_timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_CAPTURE,
        S_DRAIN
    } state_t;

    state_t                         state_q, state_d;
    logic [ID_W-1:0]                rr_ptr_q;
    logic [ID_W-1:0]                id_q;
    logic [SLOT_W-1:0]              slot_q;
    logic [IDX_W-1:0]               idx_q;
    logic [NUM_ELEM*DATA_WIDTH-1:0] buf_q;
    logic                           err_slot_q;

    logic                           grant_found;
    logic [ID_W-1:0]                grant_id;
    logic [SLOT_W-1:0]              grant_slot;
    logic                           slot_bad;
    logic [ID_W-1:0]                rr_next;
    logic                           last_elem;
    logic                           timeout_hit;

`ifdef MM_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]               wait_cnt_q;
    logic                           err_timeout_q;
`endif

    // Busy is informational only; completion is signalled by arr_done.
    logic unused_busy;
    assign unused_busy = arr_busy;

    // Round-robin search starting at rr_ptr_q, wrapping modulo NUM_REQ.
    always_comb begin
        int              cand;
        logic [ID_W-1:0] cand_id;
        // NOTE: every variable written here gets a default first, so no latch can be inferred.
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = 0;
        cand_id     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            cand_id = ID_W'(cand);
            if (!grant_found && req_valid[cand_id]) begin
                grant_found = 1'b1;
                grant_id    = cand_id;
            end
        end
    end

    assign grant_slot = SLOT_W'(req_slot >> (int'(grant_id) * SLOT_W));
    assign slot_bad   = int'(grant_slot) >= MAX_MATRICES;
    assign rr_next    = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + ID_W'(1);
    assign last_elem  = idx_q == IDX_W'(NUM_ELEM - 1);

    always_comb begin
        req_ready = '0;
        if (rst_n && state_q == S_IDLE && grant_found) req_ready[grant_id] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (grant_found && !slot_bad) state_d = S_LAUNCH;
            S_LAUNCH:  state_d = S_WAIT;
            S_WAIT: begin
                if (arr_done)         state_d = S_CAPTURE;
                else if (timeout_hit) state_d = S_IDLE;
            end
            S_CAPTURE: state_d = S_DRAIN;
            S_DRAIN:   if (res_ready && last_elem) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            id_q       <= '0;
            slot_q     <= '0;
            idx_q      <= '0;
            // NOTE: the result buffer is plain flops, not RAM, so clearing it on reset is cheap and intended.
            buf_q      <= '0;
            err_slot_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            if (state_q == S_IDLE && grant_found) begin
                rr_ptr_q <= rr_next;
                id_q     <= grant_id;
                if (slot_bad) err_slot_q <= 1'b1;
                else          slot_q     <= grant_slot;
            end
            if (state_q == S_WAIT && arr_done) buf_q <= arr_result;
            if (state_q == S_CAPTURE) begin
                idx_q <= '0;
            end else if (state_q == S_DRAIN && res_ready && !last_elem) begin
                idx_q <= idx_q + IDX_W'(1);
            end
        end
    end

`ifdef MM_SCHED_TIMEOUT_EN
    // The counter is zero on WAIT entry because every other state clears it.
    assign timeout_hit = (state_q == S_WAIT) && !arr_done &&
                         (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt_q    <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            if (state_q != S_WAIT) wait_cnt_q <= '0;
            else                   wait_cnt_q <= wait_cnt_q + CNT_W'(1);
            if (timeout_hit) err_timeout_q <= 1'b1;
        end
    end

    assign err_timeout = err_timeout_q;
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

    // Stream outputs are forced to zero outside DRAIN so reset and idle look identical.
    assign arr_start  = state_q == S_LAUNCH;
    assign arr_slot   = slot_q;
    assign res_valid  = state_q == S_DRAIN;
    assign res_data   = (state_q == S_DRAIN) ? DATA_WIDTH'(buf_q >> (int'(idx_q) * DATA_WIDTH)) : '0;
    assign res_index  = (state_q == S_DRAIN) ? idx_q : '0;
    assign res_id     = (state_q == S_DRAIN) ? id_q : '0;
    assign res_last   = (state_q == S_DRAIN) && last_elem;
    assign sched_idle = state_q == S_IDLE;
    assign err_slot   = err_slot_q;

endmodule

// File: tb/tb_mm_job_scheduler.sv
// Scoreboard bench for mm_job_scheduler: queue-based reference model of arbitration,
// array results and the output stream, checked by an independent negedge monitor.
module tb_mm_job_scheduler;

    localparam int N    = 3;
    localparam int DW   = 8;
    localparam int NR   = 2;
    localparam int MAXM = 2;
    localparam int SW   = 2;
    localparam int NE   = N * N;
    localparam int IW   = 4;
    localparam int IDW  = 1;
`ifdef MM_SCHED_TIMEOUT_EN
    localparam int TO   = 16;
`else
    localparam int TO   = 64;
`endif

    logic              clk;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR*SW-1:0]  req_slot;
    logic [NR-1:0]     req_ready;
    logic              arr_start;
    logic [SW-1:0]     arr_slot;
    logic              arr_busy;
    logic              arr_done;
    logic [NE*DW-1:0]  arr_result;
    logic              res_valid;
    logic              res_ready;
    logic [DW-1:0]     res_data;
    logic [IW-1:0]     res_index;
    logic [IDW-1:0]    res_id;
    logic              res_last;
    logic              sched_idle;
    logic              err_slot;
    logic              err_timeout;

    mm_job_scheduler #(
        .ARRAY_SIZE(N), .DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_MATRICES(MAXM),
        .SLOT_W(SW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_slot(req_slot),
        .req_ready(req_ready), .arr_start(arr_start), .arr_slot(arr_slot),
        .arr_busy(arr_busy), .arr_done(arr_done), .arr_result(arr_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_index(res_index), .res_id(res_id), .res_last(res_last),
        .sched_idle(sched_idle), .err_slot(err_slot), .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int id; int slot; } job_t;
    typedef struct { logic [DW-1:0] data; int idx; int id; bit last; } beat_t;

    int        checks   = 0;
    int        failures = 0;
    job_t      job_q[$];
    beat_t     beat_q[$];
    int        grant_log[$];
    int        model_rr = 0;
    bit        model_err_slot = 0;
    int        beats_seen = 0;
    int        starts_seen = 0;
    bit        hs_flag[NR];
    logic [SW-1:0] slot_arr[NR];
    bit        launch_pending = 0;
    int        launch_id = 0;
    bit        counting_results = 0;
    bit        array_enable = 1;
    bit        spurious_en = 0;
    int        ready_mode = 0;
    bit        prev_stall = 0;
    logic [DW-1:0] prev_data;
    logic [IW-1:0] prev_idx;

    always_comb begin
        req_slot = '0;
        for (int i = 0; i < NR; i++) req_slot[i*SW +: SW] = slot_arr[i];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arbitration: first requesting index at or after rr, wrapping.
    function automatic int exp_grant(input logic [NR-1:0] v, input int rr);
        for (int k = 0; k < NR; k++) if (v[(rr + k) % NR]) return (rr + k) % NR;
        return -1;
    endfunction

    // Monitor / scoreboard, sampling on the falling edge.
    int            mon_g;
    logic [NR-1:0] mon_ev;
    job_t          mon_j;
    beat_t         mon_b;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            check("err_slot", {63'd0, err_slot}, {63'd0, model_err_slot});
            if (req_ready != '0) begin
                mon_g  = exp_grant(req_valid, model_rr);
                mon_ev = '0;
                if (mon_g >= 0) mon_ev[mon_g] = 1'b1;
                check("req_ready_grant", 64'(req_ready), 64'(mon_ev));
                check("req_ready_only_idle", {63'd0, sched_idle}, 64'd1);
                if (mon_g >= 0) begin
                    grant_log.push_back(mon_g);
                    hs_flag[mon_g] = 1;
                    if (int'(slot_arr[mon_g]) >= MAXM) model_err_slot = 1;
                    else job_q.push_back('{mon_g, int'(slot_arr[mon_g])});
                    model_rr = (mon_g + 1) % NR;
                end
            end
            if (arr_start) begin
                starts_seen++;
                if (job_q.size() == 0) begin
                    check("arr_start_unexpected", 64'd1, 64'd0);
                end else begin
                    mon_j = job_q.pop_front();
                    check("arr_slot", 64'(arr_slot), 64'(mon_j.slot));
                    launch_id = mon_j.id;
                    if (array_enable) launch_pending = 1;
                end
            end
            if (prev_stall) begin
                check("stall_valid_held", {63'd0, res_valid}, 64'd1);
                check("stall_data_held", 64'(res_data), 64'(prev_data));
                check("stall_index_held", 64'(res_index), 64'(prev_idx));
            end
            if (res_valid) begin
                if (res_ready) begin
                    if (beat_q.size() == 0) begin
                        check("res_valid_unexpected", 64'd1, 64'd0);
                    end else begin
                        mon_b = beat_q.pop_front();
                        check("res_data", 64'(res_data), 64'(mon_b.data));
                        check("res_index", 64'(res_index), 64'(mon_b.idx));
                        check("res_id", 64'(res_id), 64'(mon_b.id));
                        check("res_last", {63'd0, res_last}, {63'd0, mon_b.last});
                    end
                    beats_seen++;
                end
                prev_stall = !res_ready;
                prev_data  = res_data;
                prev_idx   = res_index;
            end else begin
                prev_stall = 0;
            end
        end
    end

    // Array model: done after a random delay in WAIT; occasional stray done pulses otherwise.
    initial begin
        arr_done = 1'b0; arr_result = '0; arr_busy = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (launch_pending && rst_n) begin
                launch_pending = 0;
                arr_busy = 1'b1;
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
                for (int k = 0; k < NE; k++) begin
                    logic [DW-1:0] v;
                    v = counting_results ? DW'(k + 1) : DW'($urandom);
                    arr_result[k*DW +: DW] = v;
                    beat_q.push_back('{v, k, launch_id, k == NE - 1});
                end
                arr_done = 1'b1;
                @(posedge clk); #1;
                arr_done = 1'b0; arr_busy = 1'b0;
            end else if (spurious_en && $urandom_range(0, 7) == 0) begin
                arr_result = {3{$urandom}};
                arr_done = 1'b1;
                @(posedge clk); #1;
                arr_done = 1'b0;
            end
        end
    end

    initial begin
        int pat[4] = '{1, 0, 0, 1};
        int pi = 0;
        res_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       res_ready = 1'b1;
                1:       begin res_ready = pat[pi] != 0; pi = (pi + 1) % 4; end
                default: res_ready = $urandom_range(0, 1) != 0;
            endcase
        end
    end

    task automatic request(input int r, input int slot, input int budget);
        int n = 0;
        hs_flag[r] = 0;
        slot_arr[r] = SW'(slot);
        req_valid[r] = 1'b1;
        while (!hs_flag[r] && n < budget) begin @(posedge clk); #1; n++; end
        if (!hs_flag[r]) check("request_handshake_timeout", 64'd0, 64'd1);
        req_valid[r] = 1'b0;
        hs_flag[r] = 0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        do begin @(negedge clk); n++; end
        while (!(sched_idle && job_q.size() == 0 && beat_q.size() == 0 && !launch_pending) && n < budget);
        check(name, {63'd0, sched_idle && job_q.size() == 0 && beat_q.size() == 0}, 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sched_idle"}, {63'd0, sched_idle}, 64'd1);
        check({tag, "_res_valid"}, {63'd0, res_valid}, 64'd0);
        check({tag, "_res_data"}, 64'(res_data), 64'd0);
        check({tag, "_res_index"}, 64'(res_index), 64'd0);
        check({tag, "_res_id"}, 64'(res_id), 64'd0);
        check({tag, "_res_last"}, {63'd0, res_last}, 64'd0);
        check({tag, "_arr_start"}, {63'd0, arr_start}, 64'd0);
        check({tag, "_arr_slot"}, 64'(arr_slot), 64'd0);
        check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        check({tag, "_err_slot"}, {63'd0, err_slot}, 64'd0);
        check({tag, "_err_timeout"}, {63'd0, err_timeout}, 64'd0);
    endtask

    initial begin
        int b0, s0, n;
        bit pend[NR];
        rst_n = 1'b0; req_valid = '0;
        for (int i = 0; i < NR; i++) begin slot_arr[i] = '0; hs_flag[i] = 0; pend[i] = 0; end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset");

        // Both requesters held high from rr_ptr=0: grants must alternate 0,1,0,1.
        grant_log.delete();
        slot_arr[0] = 2'd0; slot_arr[1] = 2'd1;
        req_valid = 2'b11;
        n = 0;
        while (grant_log.size() < 4 && n < 500) begin @(posedge clk); #1; n++; end
        req_valid = '0;
        for (int i = 0; i < 4; i++) check("arb_order", 64'(grant_log.size() > i ? grant_log[i] : -1), 64'(i % 2));
        wait_idle("arb_drain", 300);

        // Directed job: slot 1, results 1..9, always ready.
        counting_results = 1; b0 = beats_seen; s0 = starts_seen;
        request(0, 1, 50);
        wait_idle("single_drain", 200);
        check("single_beats", 64'(beats_seen - b0), 64'(NE));
        check("single_starts", 64'(starts_seen - s0), 64'd1);

        // Backpressure pattern 1,0,0,1.
        ready_mode = 1; counting_results = 0; b0 = beats_seen;
        request(1, 0, 50);
        wait_idle("bp_drain", 300);
        check("bp_beats", 64'(beats_seen - b0), 64'(NE));

        // Out-of-range slot: handshake, sticky error, no launch.
        ready_mode = 0; s0 = starts_seen;
        request(1, 3, 50);
        repeat (10) @(negedge clk);
        check("bad_slot_err", {63'd0, err_slot}, 64'd1);
        check("bad_slot_no_start", 64'(starts_seen - s0), 64'd0);
        check("bad_slot_idle", {63'd0, sched_idle}, 64'd1);

        // Reset after the fourth beat of a stream.
        b0 = beats_seen;
        request(0, 1, 50);
        n = 0;
        while (beats_seen - b0 < 4 && n < 200) begin @(posedge clk); #1; n++; end
        check("rst_reach_beat4", 64'(beats_seen - b0), 64'd4);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        job_q.delete(); beat_q.delete();
        model_rr = 0; model_err_slot = 0; launch_pending = 0;
        @(negedge clk);
        check_reset_outputs("rst_drain");
        counting_results = 1; b0 = beats_seen;
        request(1, 0, 50);
        wait_idle("post_reset_drain", 200);
        check("post_reset_beats", 64'(beats_seen - b0), 64'(NE));

        // Randomized traffic with random backpressure and stray done pulses.
        ready_mode = 2; counting_results = 0; spurious_en = 1;
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < NR; i++) begin
                if (pend[i] && hs_flag[i]) begin
                    pend[i] = 0; hs_flag[i] = 0; req_valid[i] = 1'b0;
                end else if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i] = 1; hs_flag[i] = 0;
                    slot_arr[i] = ($urandom_range(0, 9) == 0) ? 2'd3 : SW'($urandom_range(0, 1));
                    req_valid[i] = 1'b1;
                end
            end
        end
        n = 0;
        while ((pend[0] || pend[1]) && n < 500) begin
            @(posedge clk); #1; n++;
            for (int i = 0; i < NR; i++)
                if (pend[i] && hs_flag[i]) begin pend[i] = 0; hs_flag[i] = 0; req_valid[i] = 1'b0; end
        end
        check("random_requests_served", {63'd0, pend[0] || pend[1]}, 64'd0);
        spurious_en = 0;
        wait_idle("random_drain", 1000);

`ifdef MM_SCHED_TIMEOUT_EN
        // Array never completes: watchdog must fire and drop the job.
        array_enable = 0; s0 = starts_seen;
        request(0, 1, 50);
        n = 0;
        while (starts_seen == s0 && n < 20) begin @(negedge clk); n++; end
        check("to_start_seen", 64'(starts_seen - s0), 64'd1);
        n = 0;
        while (!err_timeout && n < TO + 4) begin @(negedge clk); n++; end
        check("to_flag", {63'd0, err_timeout}, 64'd1);
        check("to_within_limit", {63'd0, n <= TO + 1}, 64'd1);
        @(negedge clk);
        check("to_idle", {63'd0, sched_idle}, 64'd1);
        array_enable = 1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
